// File: rtl/matching_pkg.sv
// Shared state encoding and saturating arithmetic for the multi-lane matching controller.
package matching_pkg;

  localparam logic [2:0] ST_IDLE          = 3'd0;
  localparam logic [2:0] ST_LFSR_INIT     = 3'd1;
  localparam logic [2:0] ST_RAND_DATA_SET = 3'd2;
  localparam logic [2:0] ST_WAIT          = 3'd3;
  localparam logic [2:0] ST_SET_FLAG      = 3'd4;
  localparam logic [2:0] ST_HALT          = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE          = ST_IDLE,
    S_LFSR_INIT     = ST_LFSR_INIT,
    S_RAND_DATA_SET = ST_RAND_DATA_SET,
    S_WAIT          = ST_WAIT,
    S_SET_FLAG      = ST_SET_FLAG,
    S_HALT          = ST_HALT
  } state_e;

  // Increment v, holding at the all-ones value of a w-bit counter (w <= 64).
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] max_v;
    max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= max_v) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/multi_matching_ctrl_lane.sv
// One matching lane: FSM, WAIT watchdog, saturating statistics and optional first-match capture.
// Capture logic is built only when MATCH_CAPTURE_EN is defined.
module matching_lane
  import matching_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_W      = 32,
  parameter int TIMEOUT    = 4096
) (
  input  logic                  i_fclk,
  input  logic                  i_reset_n,
  input  logic                  enable,
  input  logic                  halt_on_match,
  input  logic                  resume,
  input  logic                  counter_reset,
  output logic                  lfsr_init,
  output logic                  lfsr_enable,
  output logic                  data_valid,
  output logic                  result_reset,
  input  logic                  result_valid,
  input  logic                  result_match,
  input  logic                  shift_result_valid,
  input  logic [DATA_WIDTH-1:0] result_data,
  output logic [CNT_W-1:0]      match_count,
  output logic [CNT_W-1:0]      pass_count,
  output logic [CNT_W-1:0]      filter_count,
  output logic [CNT_W-1:0]      timeout_count,
  output logic                  halted,
  output logic                  set_match
`ifdef MATCH_CAPTURE_EN
  ,
  output logic [DATA_WIDTH-1:0] match_data,
  output logic                  match_data_vld
`endif
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e          state_reg, state_next;
  logic            match_reg;
  logic [WD_W-1:0] wd_reg;
  logic            wd_fire;
  logic            tmo_event;
  logic [CNT_W-1:0] match_cnt_reg, pass_cnt_reg, filter_cnt_reg, timeout_cnt_reg;

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
    logic [63:0] w;
    w = sat_inc(64'(v), CNT_W);
    return w[CNT_W-1:0];
  endfunction

  // A result arriving in the firing cycle wins over the watchdog.
  assign wd_fire   = (TIMEOUT != 0) && (state_reg == S_WAIT) && (wd_reg == WD_LAST);
  assign tmo_event = wd_fire && !result_valid;

  always_comb begin
    state_next   = state_reg;
    lfsr_init    = 1'b0;
    lfsr_enable  = 1'b0;
    data_valid   = 1'b0;
    result_reset = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (enable) state_next = S_LFSR_INIT;
      end
      S_LFSR_INIT: begin
        lfsr_init   = 1'b1;
        lfsr_enable = 1'b1;
        state_next  = S_RAND_DATA_SET;
      end
      S_RAND_DATA_SET: begin
        data_valid = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        data_valid = 1'b1;
        if (result_valid) state_next = S_SET_FLAG;
        else if (wd_fire) state_next = enable ? S_LFSR_INIT : S_IDLE;
      end
      S_SET_FLAG: begin
        if (match_reg) begin
          data_valid   = 1'b1;
          result_reset = 1'b1;
        end else begin
          lfsr_enable = 1'b1;
        end
        if (match_reg && halt_on_match) state_next = S_HALT;
        else if (!enable)               state_next = S_IDLE;
        else                            state_next = S_RAND_DATA_SET;
      end
      S_HALT: begin
        if (resume)       state_next = S_RAND_DATA_SET;
        else if (!enable) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign halted    = (state_reg == S_HALT);
  assign set_match = (state_reg == S_SET_FLAG) && match_reg;

  always_ff @(posedge i_fclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg <= S_IDLE;
      match_reg <= 1'b0;
      wd_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_WAIT && result_valid) match_reg <= result_match;
      if (state_reg != S_WAIT || TIMEOUT == 0) wd_reg <= '0;
      else                                     wd_reg <= wd_reg + WD_W'(1);
    end
  end

  // Counter clear takes priority over any increment in the same cycle.
  always_ff @(posedge i_fclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      match_cnt_reg   <= '0;
      pass_cnt_reg    <= '0;
      filter_cnt_reg  <= '0;
      timeout_cnt_reg <= '0;
    end else if (counter_reset) begin
      match_cnt_reg   <= '0;
      pass_cnt_reg    <= '0;
      filter_cnt_reg  <= '0;
      timeout_cnt_reg <= '0;
    end else begin
      if (state_reg == S_SET_FLAG) begin
        if (match_reg) match_cnt_reg <= bump(match_cnt_reg);
        else           pass_cnt_reg  <= bump(pass_cnt_reg);
      end
      if (shift_result_valid) filter_cnt_reg  <= bump(filter_cnt_reg);
      if (tmo_event)          timeout_cnt_reg <= bump(timeout_cnt_reg);
    end
  end

  assign match_count   = match_cnt_reg;
  assign pass_count    = pass_cnt_reg;
  assign filter_count  = filter_cnt_reg;
  assign timeout_count = timeout_cnt_reg;

`ifdef MATCH_CAPTURE_EN
  logic [DATA_WIDTH-1:0] cap_data_reg;
  logic                  cap_vld_reg;

  // Only the first match after reset or counter clear is kept.
  always_ff @(posedge i_fclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cap_data_reg <= '0;
      cap_vld_reg  <= 1'b0;
    end else if (counter_reset) begin
      cap_data_reg <= '0;
      cap_vld_reg  <= 1'b0;
    end else if (set_match && !cap_vld_reg) begin
      cap_data_reg <= result_data;
      cap_vld_reg  <= 1'b1;
    end
  end

  assign match_data     = cap_data_reg;
  assign match_data_vld = cap_vld_reg;
`else
  logic unused_result_data;
  assign unused_result_data = ^result_data;
`endif

endmodule

// File: rtl/multi_matching_ctrl.sv
// NUM_CH independent matching lanes with per-lane statistics and a registered any-match flag.
// Define MATCH_CAPTURE_EN to add per-lane first-match data capture ports.
module multi_matching_ctrl
  import matching_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 64,
  parameter int CNT_W      = 32,
  parameter int TIMEOUT    = 4096
) (
  input  logic                         i_fclk,
  input  logic                         i_reset_n,
  input  logic                         i_enable,
  input  logic                         i_halt_on_match,
  input  logic [NUM_CH-1:0]            i_resume,
  input  logic                         i_counter_reset,
  output logic [NUM_CH-1:0]            o_lfsr_init,
  output logic [NUM_CH-1:0]            o_lfsr_enable,
  output logic [NUM_CH-1:0]            o_data_valid,
  output logic [NUM_CH-1:0]            o_result_reset,
  input  logic [NUM_CH-1:0]            i_result_valid,
  input  logic [NUM_CH-1:0]            i_result_match,
  input  logic [NUM_CH-1:0]            i_shift_result_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_result_data,
  output logic [NUM_CH*CNT_W-1:0]      o_match_count,
  output logic [NUM_CH*CNT_W-1:0]      o_pass_count,
  output logic [NUM_CH*CNT_W-1:0]      o_filter_count,
  output logic [NUM_CH*CNT_W-1:0]      o_timeout_count,
  output logic [NUM_CH-1:0]            o_halted,
  output logic                         o_any_match
`ifdef MATCH_CAPTURE_EN
  ,
  output logic [NUM_CH*DATA_WIDTH-1:0] o_match_data,
  output logic [NUM_CH-1:0]            o_match_data_vld
`endif
);

  logic [NUM_CH-1:0] set_match;
  logic              any_match_reg;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
      matching_lane #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_W      (CNT_W),
        .TIMEOUT    (TIMEOUT)
      ) u_lane (
        .i_fclk             (i_fclk),
        .i_reset_n          (i_reset_n),
        .enable             (i_enable),
        .halt_on_match      (i_halt_on_match),
        .resume             (i_resume[gi]),
        .counter_reset      (i_counter_reset),
        .lfsr_init          (o_lfsr_init[gi]),
        .lfsr_enable        (o_lfsr_enable[gi]),
        .data_valid         (o_data_valid[gi]),
        .result_reset       (o_result_reset[gi]),
        .result_valid       (i_result_valid[gi]),
        .result_match       (i_result_match[gi]),
        .shift_result_valid (i_shift_result_valid[gi]),
        .result_data        (i_result_data[gi*DATA_WIDTH +: DATA_WIDTH]),
        .match_count        (o_match_count[gi*CNT_W +: CNT_W]),
        .pass_count         (o_pass_count[gi*CNT_W +: CNT_W]),
        .filter_count       (o_filter_count[gi*CNT_W +: CNT_W]),
        .timeout_count      (o_timeout_count[gi*CNT_W +: CNT_W]),
        .halted             (o_halted[gi]),
        .set_match          (set_match[gi])
`ifdef MATCH_CAPTURE_EN
        ,
        .match_data         (o_match_data[gi*DATA_WIDTH +: DATA_WIDTH]),
        .match_data_vld     (o_match_data_vld[gi])
`endif
      );
    end
  endgenerate

  // Registered so the flag trails the SET_FLAG cycle by exactly one clock.
  always_ff @(posedge i_fclk or negedge i_reset_n) begin
    if (!i_reset_n) any_match_reg <= 1'b0;
    else            any_match_reg <= |set_match;
  end

  assign o_any_match = any_match_reg;

endmodule

// File: tb/tb_multi_matching_ctrl.sv
module tb_multi_matching_ctrl;

  localparam int NUM_CH     = 4;
  localparam int DATA_WIDTH = 8;
  localparam int CNT_W      = 4;
  localparam int TIMEOUT    = 16;
  localparam int T0 = 4;
  localparam int B  = T0 + 36;
  localparam int E  = B + 222;

  logic                         i_fclk = 1'b0;
  logic                         i_reset_n = 1'b0;
  logic                         i_enable = 1'b0;
  logic                         i_halt_on_match = 1'b0;
  logic [NUM_CH-1:0]            i_resume = '0;
  logic                         i_counter_reset = 1'b0;
  logic [NUM_CH-1:0]            o_lfsr_init, o_lfsr_enable, o_data_valid, o_result_reset;
  logic [NUM_CH-1:0]            i_result_valid = '0;
  logic [NUM_CH-1:0]            i_result_match = '0;
  logic [NUM_CH-1:0]            i_shift_result_valid = '0;
  logic [NUM_CH*DATA_WIDTH-1:0] i_result_data = '0;
  logic [NUM_CH*CNT_W-1:0]      o_match_count, o_pass_count, o_filter_count, o_timeout_count;
  logic [NUM_CH-1:0]            o_halted;
  logic                         o_any_match;
`ifdef MATCH_CAPTURE_EN
  logic [NUM_CH*DATA_WIDTH-1:0] o_match_data;
  logic [NUM_CH-1:0]            o_match_data_vld;
`endif

  multi_matching_ctrl #(
    .NUM_CH(NUM_CH), .DATA_WIDTH(DATA_WIDTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_fclk               (i_fclk),
    .i_reset_n            (i_reset_n),
    .i_enable             (i_enable),
    .i_halt_on_match      (i_halt_on_match),
    .i_resume             (i_resume),
    .i_counter_reset      (i_counter_reset),
    .o_lfsr_init          (o_lfsr_init),
    .o_lfsr_enable        (o_lfsr_enable),
    .o_data_valid         (o_data_valid),
    .o_result_reset       (o_result_reset),
    .i_result_valid       (i_result_valid),
    .i_result_match       (i_result_match),
    .i_shift_result_valid (i_shift_result_valid),
    .i_result_data        (i_result_data),
    .o_match_count        (o_match_count),
    .o_pass_count         (o_pass_count),
    .o_filter_count       (o_filter_count),
    .o_timeout_count      (o_timeout_count),
    .o_halted             (o_halted),
    .o_any_match          (o_any_match)
`ifdef MATCH_CAPTURE_EN
    ,
    .o_match_data         (o_match_data),
    .o_match_data_vld     (o_match_data_vld)
`endif
  );

  always #5 i_fclk = ~i_fclk;

  int cyc = 0;
  always @(posedge i_fclk) cyc <= cyc + 1;

  typedef enum int {K_INIT, K_EN, K_DV, K_RR, K_HALT, K_ANY, K_MATCH, K_PASS,
                    K_FILT, K_TMO, K_MDATA, K_MVLD} kind_e;
  typedef struct {
    int          due;
    kind_e       kind;
    int          lane;
    logic [63:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic void want(input int due, input kind_e k, input int lane,
                               input logic [63:0] v, input string name);
    exp_t e;
    e = '{due, k, lane, v, name};
    sb.push_back(e);
  endfunction

  function automatic logic [63:0] observe(input kind_e k, input int lane);
    case (k)
      K_INIT:  return 64'(o_lfsr_init);
      K_EN:    return 64'(o_lfsr_enable);
      K_DV:    return 64'(o_data_valid);
      K_RR:    return 64'(o_result_reset);
      K_HALT:  return 64'(o_halted);
      K_ANY:   return 64'(o_any_match);
      K_MATCH: return 64'(o_match_count[lane*CNT_W +: CNT_W]);
      K_PASS:  return 64'(o_pass_count[lane*CNT_W +: CNT_W]);
      K_FILT:  return 64'(o_filter_count[lane*CNT_W +: CNT_W]);
      K_TMO:   return 64'(o_timeout_count[lane*CNT_W +: CNT_W]);
`ifdef MATCH_CAPTURE_EN
      K_MDATA: return 64'(o_match_data[lane*DATA_WIDTH +: DATA_WIDTH]);
      K_MVLD:  return 64'(o_match_data_vld);
`endif
      default: return '1;
    endcase
  endfunction

  always @(negedge i_fclk) begin
    logic [63:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        act = observe(sb[i].kind, sb[i].lane);
        n_checks++;
        if (act !== sb[i].exp) begin
          n_errors++;
          $display("FAIL %s lane=%0d cyc=%0d: got 0x%0h expected 0x%0h",
                   sb[i].name, sb[i].lane, cyc, act, sb[i].exp);
        end else begin
          $display("ok   %s lane=%0d cyc=%0d: 0x%0h", sb[i].name, sb[i].lane, cyc, act);
        end
        sb.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge i_fclk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  initial begin
    i_enable = 1'b1;
    goto(3);
    n_checks++;
    if (o_lfsr_init !== '0) begin
      n_errors++;
      $display("FAIL direct_rst_init cyc=%0d: got 0x%0h expected 0x0", cyc, o_lfsr_init);
    end else begin
      $display("ok   direct_rst_init cyc=%0d: 0x%0h", cyc, o_lfsr_init);
    end
    n_checks++;
    if (o_data_valid !== '0) begin
      n_errors++;
      $display("FAIL direct_rst_dv cyc=%0d: got 0x%0h expected 0x0", cyc, o_data_valid);
    end else begin
      $display("ok   direct_rst_dv cyc=%0d: 0x%0h", cyc, o_data_valid);
    end
    n_checks++;
    if (o_any_match !== 1'b0) begin
      n_errors++;
      $display("FAIL direct_rst_any cyc=%0d: got 0x%0h expected 0x0", cyc, o_any_match);
    end else begin
      $display("ok   direct_rst_any cyc=%0d: 0x%0h", cyc, o_any_match);
    end
    want(3, K_INIT, 0, 0, "rst_init");
    want(3, K_EN, 0, 0, "rst_en");
    want(3, K_DV, 0, 0, "rst_dv");
    want(3, K_ANY, 0, 0, "rst_any");
    want(3, K_HALT, 0, 0, "rst_halt");
    want(3, K_MATCH, 0, 0, "rst_match");
    want(3, K_TMO, 3, 0, "rst_tmo");
    i_reset_n = 1'b1;

    want(T0, K_INIT, 0, 4'hF, "start_init");
    want(T0, K_EN, 0, 4'hF, "start_en");
    want(T0, K_DV, 0, 0, "start_dv");
    want(T0 + 1, K_INIT, 0, 0, "rds_init");
    want(T0 + 1, K_DV, 0, 4'hF, "rds_dv");
    want(T0 + 2, K_DV, 0, 4'hF, "wait_dv");
    want(T0 + 17, K_DV, 0, 4'hF, "wait16_dv");
    want(T0 + 17, K_TMO, 3, 0, "wait16_tmo");
    want(T0 + 18, K_INIT, 0, 4'hF, "reinit");
    want(T0 + 18, K_TMO, 3, 1, "tmo_l3");
    want(T0 + 18, K_TMO, 0, 1, "tmo_l0");
    goto(T0 + 20);
    i_counter_reset = 1'b1;
    goto(T0 + 21);
    i_counter_reset = 1'b0;
    want(T0 + 21, K_TMO, 0, 0, "clr_tmo");

    goto(T0 + 35);
    i_result_valid = 4'b1000;
    goto(B);
    i_result_valid = '0;
    want(B, K_INIT, 0, 4'b0111, "race_init");
    want(B, K_EN, 0, 4'hF, "race_en");
    want(B, K_DV, 0, 0, "race_dv");
    want(B, K_TMO, 3, 0, "race_tmo3");
    want(B, K_TMO, 0, 1, "race_tmo0");
    want(B + 1, K_PASS, 3, 1, "race_pass");
    want(B + 1, K_DV, 0, 4'hF, "race_dv1");

    goto(B + 4);
    i_result_valid = 4'b0100;
    i_result_match = 4'b0100;
    goto(B + 5);
    i_result_valid = '0;
    i_result_match = '0;
    want(B + 5, K_RR, 0, 4'b0100, "m2_rr");
    want(B + 5, K_DV, 0, 4'hF, "m2_dv");
    want(B + 5, K_EN, 0, 0, "m2_en");
    want(B + 5, K_ANY, 0, 0, "m2_any0");
    want(B + 6, K_ANY, 0, 1, "m2_any1");
    want(B + 6, K_MATCH, 2, 1, "m2_cnt");
    want(B + 6, K_MATCH, 1, 0, "m2_cnt_l1");
    want(B + 6, K_PASS, 2, 0, "m2_pass");
    want(B + 6, K_RR, 0, 0, "m2_rr_end");
    want(B + 6, K_DV, 0, 4'hF, "m2_rds");
    want(B + 7, K_ANY, 0, 0, "m2_any_end");

    goto(B + 21);
    i_halt_on_match = 1'b1;
    i_result_valid  = 4'b0001;
    i_result_match  = 4'b0001;
    goto(B + 22);
    i_result_valid = '0;
    i_result_match = '0;
    want(B + 22, K_RR, 0, 4'b0001, "h0_rr");
    want(B + 23, K_HALT, 0, 4'b0001, "h0_halt");
    want(B + 23, K_DV, 0, 4'b1010, "h0_dv");
    want(B + 23, K_INIT, 0, 4'b0100, "h0_init");
    want(B + 23, K_ANY, 0, 1, "h0_any");
    want(B + 23, K_MATCH, 0, 1, "h0_cnt");
    want(B + 73, K_HALT, 0, 4'b0001, "h0_hold50");
    want(B + 123, K_HALT, 0, 4'b0001, "h0_hold100");
    goto(B + 123);
    i_resume = 4'hF;
    goto(B + 124);
    i_resume = '0;
    i_halt_on_match = 1'b0;
    want(B + 124, K_HALT, 0, 0, "res_halt");
    want(B + 124, K_DV, 0, 4'hF, "res_dv");
    want(B + 126, K_INIT, 0, 4'b1010, "res_ignored");

    goto(B + 130);
    i_result_valid = 4'b0010;
    want(B + 132, K_PASS, 1, 1, "pass_first");
    goto(B + 196);
    i_result_valid = '0;
    i_enable = 1'b0;
    want(B + 200, K_PASS, 1, 15, "pass_sat");
    want(B + 220, K_INIT, 0, 0, "park_init");
    want(B + 220, K_EN, 0, 0, "park_en");
    want(B + 220, K_DV, 0, 0, "park_dv");
    want(B + 220, K_HALT, 0, 0, "park_halt");
    goto(B + 221);
    i_enable = 1'b1;
    want(E, K_INIT, 0, 4'hF, "restart_init");

    goto(E + 3);
    i_result_valid = 4'b0010;
    goto(E + 4);
    i_result_valid  = '0;
    i_counter_reset = 1'b1;
    want(E + 4, K_EN, 0, 4'b0010, "clr_sf_en");
    want(E + 4, K_PASS, 1, 15, "clr_pre");
    goto(E + 5);
    i_counter_reset = 1'b0;
    want(E + 5, K_PASS, 1, 0, "clr_wins");
    i_shift_result_valid = 4'b1000;
    goto(E + 8);
    i_shift_result_valid = '0;
    want(E + 8, K_FILT, 3, 3, "filt3");
    want(E + 8, K_FILT, 0, 0, "filt0");

    goto(E + 9);
    i_result_data[2*DATA_WIDTH +: DATA_WIDTH] = 8'hA5;
    i_result_valid = 4'b0100;
    i_result_match = 4'b0100;
    goto(E + 10);
    i_result_valid = '0;
    i_result_match = '0;
    goto(E + 11);
    i_result_data[2*DATA_WIDTH +: DATA_WIDTH] = 8'h5A;
    goto(E + 13);
    i_result_valid = 4'b0100;
    i_result_match = 4'b0100;
    goto(E + 14);
    i_result_valid = '0;
    i_result_match = '0;
    want(E + 15, K_MATCH, 2, 2, "cap_cnt");
`ifdef MATCH_CAPTURE_EN
    want(E + 15, K_MDATA, 2, 64'hA5, "cap_data");
    want(E + 15, K_MVLD, 0, 4'b0100, "cap_vld");
`endif

    want(E + 20, K_DV, 0, 4'hF, "pre_arst_dv");
    want(E + 20, K_TMO, 0, 1, "pre_arst_tmo");
    goto(E + 21);
    i_reset_n = 1'b0;
    want(E + 21, K_DV, 0, 0, "arst_dv");
    want(E + 21, K_INIT, 0, 0, "arst_init");
    want(E + 21, K_EN, 0, 0, "arst_en");
    want(E + 21, K_ANY, 0, 0, "arst_any");
    want(E + 21, K_MATCH, 2, 0, "arst_match");
    want(E + 21, K_TMO, 0, 0, "arst_tmo");
    want(E + 21, K_FILT, 3, 0, "arst_filt");
`ifdef MATCH_CAPTURE_EN
    want(E + 21, K_MDATA, 2, 0, "arst_mdata");
    want(E + 21, K_MVLD, 0, 0, "arst_mvld");
`endif
    #1;
    n_checks++;
    if (o_data_valid !== '0) begin
      n_errors++;
      $display("FAIL direct_arst_dv cyc=%0d: got 0x%0h expected 0x0", cyc, o_data_valid);
    end else begin
      $display("ok   direct_arst_dv cyc=%0d: 0x%0h", cyc, o_data_valid);
    end
    n_checks++;
    if (o_timeout_count !== '0) begin
      n_errors++;
      $display("FAIL direct_arst_tmo cyc=%0d: got 0x%0h expected 0x0", cyc, o_timeout_count);
    end else begin
      $display("ok   direct_arst_tmo cyc=%0d: 0x%0h", cyc, o_timeout_count);
    end
    n_checks++;
    if (o_match_count !== '0) begin
      n_errors++;
      $display("FAIL direct_arst_match cyc=%0d: got 0x%0h expected 0x0", cyc, o_match_count);
    end else begin
      $display("ok   direct_arst_match cyc=%0d: 0x%0h", cyc, o_match_count);
    end
    goto(E + 25);

    while (sb.size() > 0) begin
      n_errors++;
      $display("FAIL %s never compared: due cyc=%0d expected 0x%0h",
               sb[0].name, sb[0].due, sb[0].exp);
      void'(sb.pop_front());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
